// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline output merger: channel IDs,
// the arbiter lock states, and a width helper for the FIFO level counters.
package pipeline_pkg;

   localparam int DEFAULT_DATA_W = 32;

   localparam logic CH_P1 = 1'b0;
   localparam logic CH_P2 = 1'b1;

   typedef enum logic {
      ARB_FREE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   // The number of bits needed to hold a value of 0..depth.
   function automatic int clog2_plus1(input int depth);
      int width;
      width = 0;
      for (int v = depth; v > 0; v = v >> 1) begin
         width++;
      end
      return (width == 0) ? 1 : width;
   endfunction

endpackage

// File: rtl/pipeline_output_merger_if.sv
// Stream bundle around the merger: two unqualified-by-ready result inputs and
// the merged valid/ready output tagged with its source channel.
interface pipeline_output_merger_if
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic [DATA_W-1:0] in_data_1;
   logic [DATA_W-1:0] in_data_2;
   logic [1:0]        in_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_id;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in_data_1,
      input  in_data_2,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_id,
      output out_valid
   );

   modport master (
      output in_data_1,
      output in_data_2,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_id,
      input  out_valid
   );

endinterface

// File: rtl/merge_chan_fifo.sv
// Show-ahead per-channel FIFO. The head word is visible on rd_data whenever the
// FIFO is non-empty, and a write to a full FIFO is accepted only alongside a pop.
module merge_chan_fifo
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = clog2_plus1(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  level,
   output logic              full,
   output logic              empty,
   output logic              drop
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  level_reg;
   logic              do_wr;
   logic              do_rd;

   assign full  = (level_reg == CNT_W'(DEPTH));
   assign empty = (level_reg == '0);
   assign level = level_reg;

   // When the FIFO is full, wr_ptr equals rd_ptr, so a write-with-pop lands in the
   // slot whose head word is being consumed during the same cycle.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);
   assign drop  = wr_en & ~do_wr;

   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_output_merger.sv
// Buffers the two pipeline result streams and merges them round-robin into one
// valid/ready stream. Words dropped on overflow are flagged by sticky bits.
module pipeline_output_merger
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = clog2_plus1(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   pipeline_output_merger_if.slave  bus,
   output logic [CNT_W-1:0]         level_1,
   output logic [CNT_W-1:0]         level_2,
   output logic [1:0]               overflow,
   input  logic                     clr_overflow
);

   logic [DATA_W-1:0] chan_wdata [2];
   logic [DATA_W-1:0] chan_head  [2];
   logic [CNT_W-1:0]  chan_level [2];
   logic [1:0]        chan_full;
   logic [1:0]        chan_empty;
   logic [1:0]        chan_drop;
   logic [1:0]        chan_pop;

   arb_state_t        arb_state_reg;
   logic              last_id_reg;
   logic              hold_id_reg;
   logic [1:0]        overflow_reg;

   logic              arb_id;
   logic              sel_id;
   logic              transfer;
   logic              unused_full;

   assign chan_wdata[0] = bus.in_data_1;
   assign chan_wdata[1] = bus.in_data_2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         assign chan_pop[gi] = transfer && (sel_id == 1'(gi));

         merge_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
         ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bus.in_valid[gi]),
            .wr_data (chan_wdata[gi]),
            .rd_en   (chan_pop[gi]),
            .rd_data (chan_head[gi]),
            .level   (chan_level[gi]),
            .full    (chan_full[gi]),
            .empty   (chan_empty[gi]),
            .drop    (chan_drop[gi])
         );
      end
   endgenerate

   // Full is implied by the FIFO's own accept/drop decision.
   assign unused_full = &{1'b0, chan_full};

   // Round-robin tie-break; a stalled valid keeps its channel until it is taken.
   always_comb begin
      arb_id = CH_P1;
      if (!chan_empty[0] && !chan_empty[1]) begin
         arb_id = ~last_id_reg;
      end else if (!chan_empty[1]) begin
         arb_id = CH_P2;
      end
      sel_id = (arb_state_reg == ARB_HOLD) ? hold_id_reg : arb_id;
   end

   assign bus.out_valid = ~chan_empty[sel_id];
   assign bus.out_data  = chan_head[sel_id];
   assign bus.out_id    = sel_id;
   assign transfer      = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arb_state_reg <= ARB_FREE;
         last_id_reg   <= CH_P2;
         hold_id_reg   <= CH_P1;
         overflow_reg  <= 2'b00;
      end else begin
         // A drop in the same cycle as a clear keeps the flag set.
         overflow_reg <= chan_drop | (overflow_reg & {2{~clr_overflow}});

         case (arb_state_reg)
            ARB_FREE: begin
               if (bus.out_valid) begin
                  if (bus.out_ready) begin
                     last_id_reg <= sel_id;
                  end else begin
                     arb_state_reg <= ARB_HOLD;
                     hold_id_reg   <= sel_id;
                  end
               end
            end
            ARB_HOLD: begin
               if (bus.out_ready) begin
                  last_id_reg   <= hold_id_reg;
                  arb_state_reg <= ARB_FREE;
               end
            end
            default: arb_state_reg <= ARB_FREE;
         endcase
      end
   end

   assign level_1  = chan_level[0];
   assign level_2  = chan_level[1];
   assign overflow = overflow_reg;

endmodule

// File: doc/pipeline_output_merger.md
Name: pipeline_output_merger

Overview:
- Sits directly downstream of the dual-pipeline wrapper.
- Consumes both pipelines' result streams (pipelineN_outputs plus out_valid[1:0]), which carry no back-pressure.
- Buffers each stream in a per-channel FIFO and merges them into one valid/ready stream, tagged with the source channel.
- Round-robin arbitration gives both pipelines fair drain bandwidth. Loss from overflow is reported, never silent.

Parameters:
- DATA_W, 32: width of each result word.
- DEPTH, 8: entries per channel FIFO; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1): width of the level outputs.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: asserted at 0, released at 1.
- in_data_1  input  DATA_W  result word from pipeline 1.
- in_data_2  input  DATA_W  result word from pipeline 2.
- in_valid  input  2  bit0 qualifies in_data_1, bit1 qualifies in_data_2; no ready is returned.
- out_data  output  DATA_W  merged result word.
- out_id  output  1  source of out_data: 0 = pipeline 1, 1 = pipeline 2.
- out_valid  output  1  out_data/out_id are valid.
- out_ready  input  1  consumer accepts; transfer = out_valid & out_ready.
- level_1  output  CNT_W  entries held in channel-1 FIFO.
- level_2  output  CNT_W  entries held in channel-2 FIFO.
- overflow  output  2  sticky per-channel drop flags.
- clr_overflow  input  1  clears both overflow bits.

Behaviour:
- Reset (reset==0, asynchronous):
  - Both FIFOs empty; level_1 = level_2 = 0.
  - out_valid = 0, overflow = 2'b00, last_id = 1, so channel 1 wins the first tie.
  - out_data/out_id are don't-care while out_valid = 0; the bench must not check them.
  - Reset mid-operation discards all buffered words immediately.
- Write, per channel i:
  - When in_valid[i] = 1, the word is written if level_i < DEPTH, or if level_i == DEPTH and channel i pops in the same cycle (write-while-full-with-pop is accepted).
  - Otherwise the word is dropped and overflow[i] is set at that edge.
- Read:
  - Show-ahead FIFOs; out_data is taken from the head of the selected channel.
  - A word written at edge N is presentable from the cycle after edge N. There is no same-cycle bypass.
  - Minimum input-to-output latency is 1 cycle.
- Selection:
  - If exactly one FIFO is non-empty, select it.
  - If both are non-empty, select the channel != last_id.
  - last_id updates to the selected channel only on a transfer.
  - out_valid = (selected FIFO non-empty).
- Stability rule: while out_valid = 1 and out_ready = 0, out_data, out_id and the selection are held unchanged, even if the other channel fills. This is implemented with a lock register that is set on a stalled valid and cleared on transfer.
- Pop: on a transfer, the selected FIFO pops one entry. Only one channel pops per cycle.
- Level counts:
  - level_i next = level_i + write_i - pop_i.
  - Simultaneous write and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- Throughput:
  - 1 word/cycle total at the output.
  - With both channels continuously valid the output alternates 0,1,0,1.
- Overflow:
  - overflow[i] is sticky until clr_overflow = 1.
  - If clr_overflow = 1 and a new drop occur in the same cycle, the set wins for that channel.
- Ordering: per-channel order is preserved. Cross-channel order is defined only by the arbitration above.
- No flush input: results already emitted by a pipeline are committed and must be delivered.

Decomposition:
- Shared package pipeline_pkg:
  - DATA_W default.
  - Channel ID constants CH_P1 = 1'b0 and CH_P2 = 1'b1.
  - Function clog2_plus1 for CNT_W.
- Sub-module merge_chan_fifo, instantiated twice:
  - Show-ahead synchronous FIFO with DATA_W and DEPTH parameters.
  - Ports: wr_en, wr_data, rd_en, rd_data, level, full, empty, drop pulse.
  - Same clk and async active-low reset.
- The merger holds the arbitration state (last_id, lock) plus overflow and the output mux.

Test Plan:
- Reset, then release; in_valid = 2'b01 with in_data_1 = 0x11 for 1 cycle, out_ready = 1 -> out_valid rises the next cycle with out_data = 0x11, out_id = 0, then falls; level_1 returns to 0.
- in_valid = 2'b11 for 4 cycles (ch1 0xA0..A3, ch2 0xB0..B3), out_ready = 1 -> output order A0, B0, A1, B1, A2, B2, A3, B3 with out_id 0,1,0,1,...; no overflow.
- out_ready = 0; present 0xC0 on ch2, then fill ch1 -> out_data holds 0xC0 with out_id = 1 throughout the stall; on out_ready = 1 transfer occurs and ch1 words follow.
- out_ready = 0; drive 10 words into ch1 (DEPTH = 8) -> level_1 = 8, words 9 and 10 dropped, overflow = 2'b01; drain shows exactly the first 8 words in order; pulse clr_overflow -> overflow = 0.
- Ch1 full, out_ready = 1, ch1 selected, in_valid[0] = 1 in the same cycle -> write accepted, level_1 stays 8, overflow stays 0.
- Mid-stream with level_1 = 5, assert reset asynchronously (between edges) -> out_valid and levels go to 0 immediately; after release the first new word appears with no stale data.
